// File: rtl/deinterleave_stream.sv
// rtl/deinterleave_stream.sv - round-robin CH-channel stream to per-channel N-sample blocks, BANKS buffers per channel
// Optional synchronous flush input when DEINT_FLUSH_EN is defined.
module deinterleave_stream #(
    parameter int BITS  = 8,
    parameter int CH    = 3,
    parameter int N     = 10,
    parameter int BANKS = 2,
    localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
`ifdef DEINT_FLUSH_EN
    input  logic            flush,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] data_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] data_out,
    output logic [CW-1:0]   out_ch,
    output logic            out_last
);
    localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int IW = $clog2(N);
    localparam int D  = CH * BANKS;
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int KW = $clog2(D + 1);
    localparam logic [CW-1:0] C_LAST = CW'(CH - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BANKS - 1);
    localparam logic [IW-1:0] I_LAST = IW'(N - 1);
    localparam logic [PW-1:0] P_LAST = PW'(D - 1);

    logic [BITS-1:0] mem [CH][BANKS][N];
    logic [CW-1:0]   wc;
    logic [BW-1:0]   wb [CH];
    logic [IW-1:0]   wi [CH];
    logic [BANKS-1:0] full [CH];

    // Completion FIFO: pop_ptr frees banks, ld_ptr tracks the block being read out.
    logic [CW-1:0]   fifo_ch   [D];
    logic [BW-1:0]   fifo_bank [D];
    logic [PW-1:0]   wr_ptr, ld_ptr, pop_ptr;
    logic [KW-1:0]   ld_cnt;
    logic [IW-1:0]   ri;

    logic flush_i, accept, push, load, load_last, pop;

`ifdef DEINT_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == P_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = !full[wc][wb[wc]];
    assign accept    = in_valid && in_ready && !flush_i;
    assign push      = accept && (wi[wc] == I_LAST);
    assign load      = (ld_cnt != '0) && (!out_valid || out_ready);
    assign load_last = load && (ri == I_LAST);
    assign pop       = out_valid && out_ready && out_last;

    always_ff @(posedge clk) begin
        if (accept)
            mem[wc][wb[wc]][wi[wc]] <= data_in;
        if (push) begin
            fifo_ch[wr_ptr]   <= wc;
            fifo_bank[wr_ptr] <= wb[wc];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc        <= '0;
            for (int c = 0; c < CH; c++) begin
                wb[c]   <= '0;
                wi[c]   <= '0;
                full[c] <= '0;
            end
            wr_ptr    <= '0;
            ld_ptr    <= '0;
            pop_ptr   <= '0;
            ld_cnt    <= '0;
            ri        <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (flush_i) begin
                wc <= '0;
                for (int c = 0; c < CH; c++)
                    wi[c] <= '0;
            end else if (accept) begin
                if (wi[wc] == I_LAST) begin
                    wi[wc]           <= '0;
                    full[wc][wb[wc]] <= 1'b1;
                    wb[wc]           <= (wb[wc] == B_LAST) ? '0 : wb[wc] + 1'b1;
                    wr_ptr           <= ptr_inc(wr_ptr);
                end else begin
                    wi[wc] <= wi[wc] + 1'b1;
                end
                wc <= (wc == C_LAST) ? '0 : wc + 1'b1;
            end

            // A bank being set and one being freed are never the same bank.
            if (pop) begin
                full[fifo_ch[pop_ptr]][fifo_bank[pop_ptr]] <= 1'b0;
                pop_ptr <= ptr_inc(pop_ptr);
            end

            if (push && !load_last)
                ld_cnt <= ld_cnt + 1'b1;
            else if (!push && load_last)
                ld_cnt <= ld_cnt - 1'b1;

            if (load) begin
                data_out  <= mem[fifo_ch[ld_ptr]][fifo_bank[ld_ptr]][ri];
                out_ch    <= fifo_ch[ld_ptr];
                out_last  <= (ri == I_LAST);
                out_valid <= 1'b1;
                if (ri == I_LAST) begin
                    ri     <= '0;
                    ld_ptr <= ptr_inc(ld_ptr);
                end else begin
                    ri <= ri + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_deinterleave_stream.sv
// tb/tb_deinterleave_stream.sv - self-checking bench for deinterleave_stream
// Queue-based reference model plus table-driven sequences; flush test under DEINT_FLUSH_EN.
module tb_deinterleave_stream;
    localparam int CH = 3, N = 4, BANKS = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 0, in_ready, out_valid, out_ready = 0, out_last;
    logic [7:0] data_in = 0, data_out;
    logic [1:0] out_ch;
    logic       s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0, s_out_last;
    logic [7:0] s_data_in = 0, s_data_out;
    logic [0:0] s_out_ch;
`ifdef DEINT_FLUSH_EN
    logic       flush = 0;
    logic       s_flush = 0;
`endif

    deinterleave_stream #(.BITS(8), .CH(CH), .N(N), .BANKS(BANKS)) u_dut (
        .clk(clk), .rst(rst),
`ifdef DEINT_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_ch(out_ch), .out_last(out_last));

    deinterleave_stream #(.BITS(8), .CH(1), .N(2), .BANKS(1)) u_small (
        .clk(clk), .rst(rst),
`ifdef DEINT_FLUSH_EN
        .flush(s_flush),
`endif
        .in_valid(s_in_valid), .in_ready(s_in_ready), .data_in(s_data_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .data_out(s_data_out),
        .out_ch(s_out_ch), .out_last(s_out_last));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: partial blocks per channel, ordered list of expected output words,
    // and count of completed-but-unread blocks per channel.
    typedef struct { logic [7:0] d; int ch; logic last; } word_t;
    word_t      exp_q[$];
    logic [7:0] part_d [CH][N];
    int         part_n [CH];
    int         outstanding [CH];
    int         m_wc;

    logic       prev_stall;
    logic [7:0] prev_d;
    logic [1:0] prev_ch;
    logic       prev_last;
    logic       s_ov, s_rdy, s_acc, s_last;
    logic [7:0] s_d;
    logic [1:0] s_ch;

    task automatic model_reset();
        exp_q.delete();
        for (int c = 0; c < CH; c++) begin
            part_n[c] = 0;
            outstanding[c] = 0;
        end
        m_wc = 0;
        prev_stall = 0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic fl);
        logic exp_rdy;
        @(negedge clk);
        in_valid = v;
        data_in = d;
        out_ready = r;
`ifdef DEINT_FLUSH_EN
        flush = fl;
`endif
        #1;
        exp_rdy = (outstanding[m_wc] < BANKS);
        check("in_ready", in_ready, exp_rdy);
        if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", data_out, prev_d);
            check("stall_ch", out_ch, prev_ch);
            check("stall_last", out_last, prev_last);
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got data %0h with no block expected", data_out);
            end else begin
                check("out_data", data_out, exp_q[0].d);
                check("out_ch", out_ch, exp_q[0].ch[1:0]);
                check("out_last", out_last, exp_q[0].last);
            end
        end
        s_ov = out_valid; s_rdy = in_ready; s_d = data_out; s_ch = out_ch; s_last = out_last;
        prev_stall = out_valid && !r;
        prev_d = data_out; prev_ch = out_ch; prev_last = out_last;
        s_acc = v && exp_rdy && !fl;
        if (fl) begin
            for (int c = 0; c < CH; c++) part_n[c] = 0;
            m_wc = 0;
        end else if (s_acc) begin
            part_d[m_wc][part_n[m_wc]] = d;
            part_n[m_wc]++;
            if (part_n[m_wc] == N) begin
                for (int i = 0; i < N; i++)
                    exp_q.push_back('{part_d[m_wc][i], m_wc, (i == N - 1)});
                outstanding[m_wc]++;
                part_n[m_wc] = 0;
            end
            m_wc = (m_wc + 1) % CH;
        end
        if (out_valid && r && exp_q.size() > 0) begin
            if (exp_q[0].last) outstanding[exp_q[0].ch]--;
            void'(exp_q.pop_front());
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++)
            step(0, 8'h00, 1, 0);
        check("drain_done", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        in_valid = 0; out_ready = 0; s_in_valid = 0; s_out_ready = 0;
`ifdef DEINT_FLUSH_EN
        flush = 0;
`endif
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_out_ch", out_ch, 2'd0);
        check("rst_out_last", out_last, 1'b0);
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    typedef struct { logic [7:0] din; logic [7:0] dout; logic [1:0] ch; logic last; } vec_t;
    typedef struct { logic rdy; logic ov; logic [7:0] d; logic last; } svec_t;
    vec_t  t1 [12];
    svec_t sm [11];
    logic [7:0] samp [4];

    initial begin
        int wait_n, sent, got, nwords, s_idx;
        logic [7:0] first_d;

        t1[0]  = '{8'h01, 8'h01, 2'd0, 1'b0};  t1[1]  = '{8'h02, 8'h04, 2'd0, 1'b0};
        t1[2]  = '{8'h03, 8'h07, 2'd0, 1'b0};  t1[3]  = '{8'h04, 8'h0A, 2'd0, 1'b1};
        t1[4]  = '{8'h05, 8'h02, 2'd1, 1'b0};  t1[5]  = '{8'h06, 8'h05, 2'd1, 1'b0};
        t1[6]  = '{8'h07, 8'h08, 2'd1, 1'b0};  t1[7]  = '{8'h08, 8'h0B, 2'd1, 1'b1};
        t1[8]  = '{8'h09, 8'h03, 2'd2, 1'b0};  t1[9]  = '{8'h0A, 8'h06, 2'd2, 1'b0};
        t1[10] = '{8'h0B, 8'h09, 2'd2, 1'b0};  t1[11] = '{8'h0C, 8'h0C, 2'd2, 1'b1};
        samp[0] = 8'hA1; samp[1] = 8'hB2; samp[2] = 8'hC3; samp[3] = 8'hD4;
        sm[0] = '{1, 0, 8'h00, 0}; sm[1] = '{1, 0, 8'h00, 0}; sm[2]  = '{0, 0, 8'h00, 0};
        sm[3] = '{0, 1, 8'hA1, 0}; sm[4] = '{0, 1, 8'hB2, 1}; sm[5]  = '{1, 0, 8'h00, 0};
        sm[6] = '{1, 0, 8'h00, 0}; sm[7] = '{0, 0, 8'h00, 0}; sm[8]  = '{0, 1, 8'hC3, 0};
        sm[9] = '{0, 1, 8'hD4, 1}; sm[10] = '{1, 0, 8'h00, 0};

        repeat (2) @(negedge clk);
        do_reset();

        // Continuous stream 01..0C: ch0 word 0 two cycles after 0x0A, then back-to-back blocks.
        for (int t = 0; t < 25; t++) begin
            step(t < 12, (t < 12) ? t1[t].din : 8'h00, 1, 0);
            if (t < 11) begin
                check("t1_idle", s_ov, 1'b0);
            end else if (t < 23) begin
                check("t1_valid", s_ov, 1'b1);
                check("t1_data", s_d, t1[t - 11].dout);
                check("t1_ch", s_ch, t1[t - 11].ch);
                check("t1_last", s_last, t1[t - 11].last);
            end
        end

        // Backpressure: two blocks per channel fill every bank; 25th sample is refused.
        do_reset();
        for (int i = 0; i < 24; i++) step(1, 8'(8'h20 + i), 0, 0);
        step(1, 8'h38, 0, 0);
        check("t2_full", s_rdy, 1'b0);
        wait_n = -1;
        for (int i = 0; i < 20; i++) begin
            step(1, 8'h38, 1, 0);
            if (s_acc) begin
                wait_n = i;
                break;
            end
        end
        check("t2_release", wait_n, 4);
        step(0, 8'h00, 0, 0);
        check("t2_busy_before_rst", s_ov, 1'b1);
        do_reset();

        // Random valid/ready over 100 blocks.
        sent = 0;
        for (int c = 0; c < 20000 && sent < 400; c++) begin
            step(($urandom % 4) != 0, 8'($urandom), 1'($urandom % 2), 0);
            if (s_acc) sent++;
        end
        check("t3_sent", sent, 400);
        drain();

        // Reset after 5 of 12 samples, then a clean run.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 1, 0);
        do_reset();
        got = 0;
        first_d = 8'h00;
        for (int t = 0; t < 30; t++) begin
            step(t < 12, 8'(8'h50 + t), 1, 0);
            if (s_ov && got == 0) begin
                got = 1;
                first_d = s_d;
                check("t4_first_ch", s_ch, 2'd0);
            end
        end
        check("t4_first_data", first_d, 8'h50);
        check("t4_empty", exp_q.size(), 0);

`ifdef DEINT_FLUSH_EN
        do_reset();
        step(1, 8'h77, 1, 0);
        step(1, 8'h78, 1, 0);
        step(1, 8'hEE, 1, 1);
        nwords = 0;
        for (int t = 0; t < 30; t++) begin
            step(t < 12, 8'(8'h10 + t), 1, 0);
            if (s_ov) begin
                nwords++;
                if (nwords == 1) check("fl_first", s_d, 8'h10);
            end
        end
        check("fl_words", nwords, 12);
`endif

        // Single channel, single bank: refused while the only bank awaits readout.
        do_reset();
        s_idx = 0;
        for (int t = 0; t < 11; t++) begin
            @(negedge clk);
            s_in_valid = (s_idx < 4);
            s_data_in = samp[s_idx % 4];
            s_out_ready = 1;
            #1;
            check("sm_ready", s_in_ready, sm[t].rdy);
            check("sm_valid", s_out_valid, sm[t].ov);
            if (sm[t].ov) begin
                check("sm_data", s_data_out, sm[t].d);
                check("sm_last", s_out_last, sm[t].last);
            end
            if (s_in_valid && s_in_ready) s_idx++;
        end
        check("sm_all_sent", s_idx, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
